time_display_driver: RTL

Consumer end of the clock's time-value interface: takes the binary seconds/minutes/hours buses from the timer and drives six active-low 7-segment digits on the MAX 10 board. It free-runs a multi-cycle repeated-subtraction binary-to-BCD converter over a coherent snapshot of all three fields. It commits results atomically and registers the segment outputs. It can optionally blink the field currently selected for adjustment.

---
 rtl/time_display_driver.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/time_display_driver.sv
// time_display_driver: converts coherent binary h:m:s snapshots to six active-low
// 7-segment digits using a free-running repeated-subtraction BCD converter.
// Optional feature macro: TIME_DISPLAY_BLINK_EN (blinks the field selected by sel_*).
module time_display_driver #(
    parameter int unsigned CLOCK_FREQ = 50_000_000,
    parameter int unsigned BLINK_HZ   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] i_seconds,
    input  logic [5:0] i_minutes,
    input  logic [6:0] i_hours,
    input  logic       sel_seconds,
    input  logic       sel_minutes,
    input  logic       sel_hours,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       conv_busy,
    output logic       range_err
);

    typedef enum logic [2:0] {StIdle, StLoad, StDivS, StDivM, StDivH, StCommit} state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam int unsigned HALF     = CLOCK_FREQ / (2 * BLINK_HZ);

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    state_e     r_state;
    logic [5:0] r_rem_s, r_rem_m;
    logic [6:0] r_rem_h;
    logic [3:0] r_ten_s, r_ten_m, r_ten_h;
    logic       r_ill_s, r_ill_m, r_ill_h;
    // Committed snapshot: only ever written together in StCommit
    logic [3:0] r_sec_ones, r_sec_tens, r_min_ones, r_min_tens, r_hr_ones, r_hr_tens;
    logic       r_cill_s, r_cill_m, r_cill_h;
    logic       r_valid;
    logic       r_range_err, r_conv_busy;
    logic [6:0] r_hex0, r_hex1, r_hex2, r_hex3, r_hex4, r_hex5;
    logic [6:0] w_hex0, w_hex1, w_hex2, w_hex3, w_hex4, w_hex5;
    logic       w_blank_s, w_blank_m, w_blank_h;

    // Conversion FSM: snapshot, divide each field by repeated subtraction, commit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_conv_busy <= 1'b0;
            r_range_err <= 1'b0;
            r_valid     <= 1'b0;
            r_rem_s     <= '0;
            r_rem_m     <= '0;
            r_rem_h     <= '0;
            r_ten_s     <= '0;
            r_ten_m     <= '0;
            r_ten_h     <= '0;
            r_ill_s     <= 1'b0;
            r_ill_m     <= 1'b0;
            r_ill_h     <= 1'b0;
            r_sec_ones  <= '0;
            r_sec_tens  <= '0;
            r_min_ones  <= '0;
            r_min_tens  <= '0;
            r_hr_ones   <= '0;
            r_hr_tens   <= '0;
            r_cill_s    <= 1'b0;
            r_cill_m    <= 1'b0;
            r_cill_h    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_state     <= StLoad;
                    r_conv_busy <= 1'b1;
                end
                StLoad: begin
                    r_rem_s <= i_seconds;
                    r_rem_m <= i_minutes;
                    r_rem_h <= i_hours;
                    r_ten_s <= '0;
                    r_ten_m <= '0;
                    r_ten_h <= '0;
                    r_ill_s <= (i_seconds > 6'd59);
                    r_ill_m <= (i_minutes > 6'd59);
                    r_ill_h <= (i_hours > 7'd23);
                    r_state <= StDivS;
                end
                StDivS: begin
                    if (r_rem_s >= 6'd10) begin
                        r_rem_s <= r_rem_s - 6'd10;
                        r_ten_s <= r_ten_s + 4'd1;
                    end else begin
                        r_state <= StDivM;
                    end
                end
                StDivM: begin
                    if (r_rem_m >= 6'd10) begin
                        r_rem_m <= r_rem_m - 6'd10;
                        r_ten_m <= r_ten_m + 4'd1;
                    end else begin
                        r_state <= StDivH;
                    end
                end
                StDivH: begin
                    if (r_rem_h >= 7'd10) begin
                        r_rem_h <= r_rem_h - 7'd10;
                        r_ten_h <= r_ten_h + 4'd1;
                    end else begin
                        r_state     <= StCommit;
                        r_conv_busy <= 1'b0;
                    end
                end
                StCommit: begin
                    r_sec_ones  <= r_rem_s[3:0];
                    r_sec_tens  <= r_ten_s;
                    r_min_ones  <= r_rem_m[3:0];
                    r_min_tens  <= r_ten_m;
                    r_hr_ones   <= r_rem_h[3:0];
                    r_hr_tens   <= r_ten_h;
                    r_cill_s    <= r_ill_s;
                    r_cill_m    <= r_ill_m;
                    r_cill_h    <= r_ill_h;
                    r_range_err <= r_ill_s | r_ill_m | r_ill_h;
                    r_valid     <= 1'b1;
                    r_state     <= StLoad;
                    r_conv_busy <= 1'b1;
                end
                default: begin
                    r_state     <= StIdle;
                    r_conv_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef TIME_DISPLAY_BLINK_EN
    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] r_blink_cnt;
    logic          r_phase;

    // Blink phase generator: toggles every HALF cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == CW'(HALF - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    assign w_blank_s = sel_seconds & r_phase;
    assign w_blank_m = sel_minutes & r_phase;
    assign w_blank_h = sel_hours & r_phase;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{sel_seconds, sel_minutes, sel_hours, (HALF == 0)};
    assign w_blank_s    = 1'b0;
    assign w_blank_m    = 1'b0;
    assign w_blank_h    = 1'b0;
`endif

    // Segment decode of the committed snapshot; blanking overrides digits and dashes
    always_comb begin
        w_hex0 = SEG_BLANK;
        w_hex1 = SEG_BLANK;
        w_hex2 = SEG_BLANK;
        w_hex3 = SEG_BLANK;
        w_hex4 = SEG_BLANK;
        w_hex5 = SEG_BLANK;
        if (r_valid) begin
            w_hex0 = r_cill_s ? SEG_DASH : seg_encode(r_sec_ones);
            w_hex1 = r_cill_s ? SEG_DASH : seg_encode(r_sec_tens);
            w_hex2 = r_cill_m ? SEG_DASH : seg_encode(r_min_ones);
            w_hex3 = r_cill_m ? SEG_DASH : seg_encode(r_min_tens);
            w_hex4 = r_cill_h ? SEG_DASH : seg_encode(r_hr_ones);
            w_hex5 = r_cill_h ? SEG_DASH : seg_encode(r_hr_tens);
        end
        if (w_blank_s) begin
            w_hex0 = SEG_BLANK;
            w_hex1 = SEG_BLANK;
        end
        if (w_blank_m) begin
            w_hex2 = SEG_BLANK;
            w_hex3 = SEG_BLANK;
        end
        if (w_blank_h) begin
            w_hex4 = SEG_BLANK;
            w_hex5 = SEG_BLANK;
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hex0 <= SEG_BLANK;
            r_hex1 <= SEG_BLANK;
            r_hex2 <= SEG_BLANK;
            r_hex3 <= SEG_BLANK;
            r_hex4 <= SEG_BLANK;
            r_hex5 <= SEG_BLANK;
        end else begin
            r_hex0 <= w_hex0;
            r_hex1 <= w_hex1;
            r_hex2 <= w_hex2;
            r_hex3 <= w_hex3;
            r_hex4 <= w_hex4;
            r_hex5 <= w_hex5;
        end
    end

    assign hex0      = r_hex0;
    assign hex1      = r_hex1;
    assign hex2      = r_hex2;
    assign hex3      = r_hex3;
    assign hex4      = r_hex4;
    assign hex5      = r_hex5;
    assign conv_busy = r_conv_busy;
    assign range_err = r_range_err;

endmodule
